// File: rtl/nbit_counter_mod.sv
// rtl/nbit_counter_mod.sv - N-bit up/down modulo counter with prescaler, clear, load and wrap pulse
// Optional sticky overflow flag (ovf_sticky, clr_ovf) is enabled by defining NBC_STICKY_OVF_EN.
module nbit_counter_mod #(
    parameter int             N   = 8,
    parameter logic [N-1:0]   MAX = {N{1'b1}},
    parameter int             DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         wrap,
    output logic         zero
`ifdef NBC_STICKY_OVF_EN
    ,
    input  logic         clr_ovf,
    output logic         ovf_sticky
`endif
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic [N-1:0]  r_count;
    logic          r_wrap;

    logic          w_step;
    logic          w_at_term;
    logic          w_wrap_ev;
    logic [N-1:0]  w_next;
    logic [N-1:0]  w_load_clamped;

    // A step only counts when clear and load are not overriding it this edge.
    assign w_step         = en && (r_pre == PRE_LAST);
    assign w_at_term      = up ? (r_count == MAX) : (r_count == '0);
    assign w_wrap_ev      = !clear && !load && w_step && w_at_term;
    assign w_next         = up ? ((r_count == MAX) ? '0  : r_count + N'(1))
                               : ((r_count == '0)  ? MAX : r_count - N'(1));
    assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_pre   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_ev;
            if (clear) begin
                r_count <= '0;
                r_pre   <= '0;
            end else if (load) begin
                r_count <= w_load_clamped;
                r_pre   <= '0;
            end else if (en) begin
                if (w_step) begin
                    r_count <= w_next;
                    r_pre   <= '0;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign zero  = (r_count == '0);

`ifdef NBC_STICKY_OVF_EN
    logic r_ovf_sticky;

    // A wrap in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_wrap_ev) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_nbit_counter_mod.sv
// tb/tb_nbit_counter_mod.sv - scoreboard bench for nbit_counter_mod (MAX=9/DIV=1 and MAX=255/DIV=3 instances)
module tb_nbit_counter_mod;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, up, clear, load, clr_ovf;
    logic [7:0] load_val;

    logic [3:0] count_a;
    logic       wrap_a, zero_a;
    logic [7:0] count_b;
    logic       wrap_b, zero_b;
    logic       ovf_a, ovf_b;

    nbit_counter_mod #(.N(4), .MAX(4'd9), .DIV(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(count_a), .wrap(wrap_a), .zero(zero_a)
`ifdef NBC_STICKY_OVF_EN
        , .clr_ovf(clr_ovf), .ovf_sticky(ovf_a)
`endif
    );

    nbit_counter_mod #(.N(8), .DIV(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(count_b), .wrap(wrap_b), .zero(zero_b)
`ifdef NBC_STICKY_OVF_EN
        , .clr_ovf(clr_ovf), .ovf_sticky(ovf_b)
`endif
    );

`ifndef NBC_STICKY_OVF_EN
    assign ovf_a = 1'b0;
    assign ovf_b = 1'b0;
`endif

    typedef struct {
        int cnt;
        bit wrp;
        bit zro;
        bit ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: enabled cycles seen since the last step, counted 0..DIV.
    int m_cnt[2];
    int m_seen[2];
    bit m_wrap[2];
    bit m_ovf[2];
    int c_max[2] = '{9, 255};
    int c_div[2] = '{1, 3};
    int c_lvmask[2] = '{15, 255};

    function automatic exp_t model_edge(input int k, input bit r, e, u, c, l,
                                        input int lv, input bit co);
        exp_t x;
        bit   wrapped;
        int   v;
        wrapped = 0;
        if (r) begin
            m_cnt[k] = 0; m_seen[k] = 0; m_ovf[k] = 0;
        end else if (c) begin
            m_cnt[k] = 0; m_seen[k] = 0;
        end else if (l) begin
            v = lv & c_lvmask[k];
            m_cnt[k] = (v > c_max[k]) ? c_max[k] : v;
            m_seen[k] = 0;
        end else if (e) begin
            m_seen[k] = m_seen[k] + 1;
            if (m_seen[k] == c_div[k]) begin
                m_seen[k] = 0;
                if (u) begin
                    if (m_cnt[k] == c_max[k]) begin m_cnt[k] = 0; wrapped = 1; end
                    else m_cnt[k] = m_cnt[k] + 1;
                end else begin
                    if (m_cnt[k] == 0) begin m_cnt[k] = c_max[k]; wrapped = 1; end
                    else m_cnt[k] = m_cnt[k] - 1;
                end
            end
        end
        m_wrap[k] = wrapped;
        if (!r) begin
            if (wrapped) m_ovf[k] = 1;
            else if (co) m_ovf[k] = 0;
        end
        x.cnt = m_cnt[k];
        x.wrp = m_wrap[k];
        x.zro = (m_cnt[k] == 0);
`ifdef NBC_STICKY_OVF_EN
        x.ovf = m_ovf[k];
`else
        x.ovf = 0;
`endif
        return x;
    endfunction

    task automatic drive(input bit r, e, u, c, l, input int lv, input bit co);
        reset    = r;
        en       = e;
        up       = u;
        clear    = c;
        load     = l;
        load_val = lv[7:0];
        clr_ovf  = co;
        q_a.push_back(model_edge(0, r, e, u, c, l, lv, co));
        q_b.push_back(model_edge(1, r, e, u, c, l, lv, co));
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("a_count", int'(count_a), ea.cnt);
            chk("a_wrap",  int'(wrap_a),  int'(ea.wrp));
            chk("a_zero",  int'(zero_a),  int'(ea.zro));
`ifdef NBC_STICKY_OVF_EN
            chk("a_ovf",   int'(ovf_a),   int'(ea.ovf));
`endif
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("b_count", int'(count_b), eb.cnt);
            chk("b_wrap",  int'(wrap_b),  int'(eb.wrp));
            chk("b_zero",  int'(zero_b),  int'(eb.zro));
`ifdef NBC_STICKY_OVF_EN
            chk("b_ovf",   int'(ovf_b),   int'(eb.ovf));
`endif
        end
    end

    initial begin
        reset = 1; en = 0; up = 1; clear = 0; load = 0; load_val = 0; clr_ovf = 0;

        repeat (2) drive(1, 0, 1, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 1, 0, 0, 0, 0);

        drive(1, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 1, 0, 1, 12, 0);
        drive(0, 1, 1, 1, 1, 5, 0);
        drive(0, 0, 1, 0, 1, 255, 0);
        repeat (4) drive(0, 1, 1, 0, 0, 0, 0);

        drive(1, 0, 1, 0, 0, 0, 0);
        repeat (9) drive(0, 1, 1, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 1, 0, 0, 0, 0);

        drive(0, 0, 1, 0, 1, 17, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0, 0, 0, 0);

        drive(1, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 9, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        repeat (10) drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 9, 0);
        drive(0, 1, 1, 0, 0, 0, 1);
        repeat (2) drive(0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 14) == 0),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) == 0));
        end

        for (int i = 0; i < 10; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending_a=%0d pending_b=%0d required=0", q_a.size(), q_b.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nbit_counter_mod.md
NBIT_COUNTER_MOD -- requirements
Module: nbit_counter_mod

Interface
REQ-001 Parameter N, default 8: counter width in bits, 2..32.
REQ-002 Parameter MAX, default 2**N-1: terminal value; count range 0..MAX; MAX must be ≤ 2**N-1.
REQ-003 Parameter DIV, default 1: prescale ratio; count steps once per DIV enabled cycles; DIV ≥ 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  count enable; low holds count and prescaler.
REQ-007 up  in  1  direction; 1 = increment, 0 = decrement.
REQ-008 clear  in  1  synchronous clear of count and prescaler.
REQ-009 load  in  1  synchronous load of load_val.
REQ-010 load_val  in  N  value to load.
REQ-011 count  out  N  registered count value.
REQ-012 wrap  out  1  registered one-cycle pulse after a wrap event.
REQ-013 zero  out  1  combinational, high when count == 0.

Function
REQ-014 Priority per edge SHALL be: reset > clear > load > step > hold.
REQ-015 Internal prescaler pre (0..DIV-1) SHALL increment when en=1 and no clear/load; step fires when en=1 and pre==DIV-1, and pre returns to 0 on that step.
REQ-016 With DIV=1, a step SHALL fire on every cycle with en=1.
REQ-017 Up step: count<MAX → count+1; count==MAX → 0 and wrap event.
REQ-018 Down step: count>0 → count-1; count==0 → MAX and wrap event.
REQ-019 wrap SHALL be high for exactly the one cycle following the edge that performed a wrap event; it is low otherwise.
REQ-020 load SHALL set count to load_val, clamped to MAX if load_val > MAX; pre set to 0; no wrap event.
REQ-021 clear SHALL set count and pre to 0; no wrap event; clear with load simultaneously gives count=0.
REQ-022 en=0 SHALL freeze count and pre; wrap falls to 0 on the next edge.
REQ-023 Changing up between steps SHALL not reset pre; direction is sampled only on the stepping edge.
REQ-024 All arithmetic SHALL be N bits wide with no unintended truncation for MAX = 2**N-1.

Reset
REQ-025 On reset=1 at a rising edge: count=0, pre=0, wrap=0, ovf_sticky=0 (when present); zero then reads 1.
REQ-026 Reset asserted mid-prescale or mid-count SHALL discard all progress; counting resumes from pre=0 on the first edge with reset=0.

Configuration
REQ-027 Macro NBC_STICKY_OVF_EN defined: adds output ovf_sticky (1 bit) and input clr_ovf (1 bit); ovf_sticky sets on any wrap event and holds until clr_ovf=1 or reset; set has priority over clr_ovf in the same cycle.
REQ-028 Macro NBC_STICKY_OVF_EN undefined: ovf_sticky and clr_ovf do not exist; all other behaviour identical.

Verification
REQ-029 N=4, MAX=9, DIV=1, reset then en=1, up=1 for 12 cycles → count 0,1..9,0,1; wrap high exactly one cycle, after 9→0.
REQ-030 N=4, MAX=9, count=0, up=0, en=1 one cycle → count=9, wrap pulse 1 cycle, zero goes 1→0.
REQ-031 N=4, MAX=9, load=1, load_val=12 → count=9; load=1 and clear=1 with load_val=5 → count=0.
REQ-032 N=8, MAX=255, DIV=3, en=1, up=1 for 9 cycles → count=3; en=0 for 4 cycles, then en=1 for 1 cycle → count still 3, steps on the 2nd enabled cycle after that.
REQ-033 N=5, count=17, reset=1 one cycle mid-prescale → count=0, wrap=0, zero=1; next step after DIV enabled cycles.
REQ-034 With NBC_STICKY_OVF_EN: wrap at 9→0 → ovf_sticky=1 held 10 cycles; clr_ovf=1 → ovf_sticky=0 next cycle; clr_ovf coincident with wrap → ovf_sticky stays 1.
